// File: rtl/i2c_pkg.sv
// Shared I2C master types: FSM state encoding, R/W bit values and default device address.
// Pure declarations; no logic, no latency, no flow control.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        CTRL_W,
        ADDR_HI,
        ADDR_LO,
        DATA_WR,
        RESTART,
        CTRL_R,
        DATA_RD,
        STOP
    } state_t;

    localparam logic       RW_WRITE       = 1'b0;
    localparam logic       RW_READ        = 1'b1;
    localparam logic [6:0] DEF_SLAVE_ADDR = 7'h50;

endpackage

// File: rtl/i2c_tick_gen.sv
// Free-running clock-enable at four times the SCL rate (one pulse every QDIV clk cycles).
// Single-cycle tick, registered; no backpressure.
module i2c_tick_gen #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int I2C_FREQ = 250_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int QDIV = CLK_FREQ / (I2C_FREQ * 4);
    localparam int CW   = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(QDIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == LAST);
            cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_byte_master.sv
// Single-byte I2C EEPROM-style master (write or random read); i2c_done pulses one cycle after STOP.
// i2c_exec is dropped while busy; I2C_ADDR16_EN selects a 16-bit word address (8-bit when undefined).
module i2c_byte_master
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = DEF_SLAVE_ADDR,
    parameter int         CLK_FREQ   = 50_000_000,
    parameter int         I2C_FREQ   = 250_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i2c_exec,
    input  logic        i2c_rh_wl,
    input  logic [15:0] i2c_addr,
    input  logic [7:0]  i2c_data_w,
    output logic [7:0]  i2c_data_r,
    output logic        i2c_done,
    output logic        i2c_ack,
    output logic        i2c_busy,
    output logic        scl,
    inout  wire         sda
);

    state_t      state;
    logic        tick;
    logic [1:0]  qtr;
    logic [3:0]  bitcnt;
    logic        sda_rel;
    logic        finish;
    logic        rw_q;
    logic [15:0] addr_q;
    logic [7:0]  wdat_q;
    logic [7:0]  rx_sh;
    logic [7:0]  tx_byte;
    logic        tx_bit;
    state_t      nxt_byte;

    i2c_tick_gen #(.CLK_FREQ(CLK_FREQ), .I2C_FREQ(I2C_FREQ)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign sda = sda_rel ? 1'bz : 1'b0;

    always_comb begin
        tx_byte = 8'hFF;
        case (state)
            CTRL_W:  tx_byte = {SLAVE_ADDR, RW_WRITE};
            ADDR_HI: tx_byte = addr_q[15:8];
            ADDR_LO: tx_byte = addr_q[7:0];
            DATA_WR: tx_byte = wdat_q;
            CTRL_R:  tx_byte = {SLAVE_ADDR, RW_READ};
            default: tx_byte = 8'hFF;
        endcase
        tx_bit = tx_byte[3'd7 - bitcnt[2:0]];
    end

    always_comb begin
        nxt_byte = STOP;
        case (state)
`ifdef I2C_ADDR16_EN
            CTRL_W:  nxt_byte = ADDR_HI;
`else
            CTRL_W:  nxt_byte = ADDR_LO;
`endif
            ADDR_HI: nxt_byte = ADDR_LO;
            ADDR_LO: nxt_byte = (rw_q == RW_READ) ? RESTART : DATA_WR;
            CTRL_R:  nxt_byte = DATA_RD;
            default: nxt_byte = STOP;
        endcase
    end

    // Each bit spans four ticks: q0 drive sda (SCL low), q1 SCL high, q2 sample, q3 SCL low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            scl        <= 1'b1;
            sda_rel    <= 1'b1;
            i2c_done   <= 1'b0;
            i2c_ack    <= 1'b0;
            i2c_busy   <= 1'b0;
            i2c_data_r <= 8'h00;
            qtr        <= 2'd0;
            bitcnt     <= 4'd0;
            finish     <= 1'b0;
            rw_q       <= RW_WRITE;
            addr_q     <= 16'h0000;
            wdat_q     <= 8'h00;
            rx_sh      <= 8'h00;
        end else begin
            i2c_done <= 1'b0;
            if (i2c_done)
                i2c_busy <= 1'b0;
            if (finish) begin
                finish   <= 1'b0;
                i2c_done <= 1'b1;
                state    <= IDLE;
            end else if (state == IDLE) begin
                if (i2c_exec && !i2c_busy) begin
                    rw_q     <= i2c_rh_wl;
                    addr_q   <= i2c_addr;
                    wdat_q   <= i2c_data_w;
                    i2c_ack  <= 1'b0;
                    i2c_busy <= 1'b1;
                    qtr      <= 2'd0;
                    bitcnt   <= 4'd0;
                    state    <= START;
                end
            end else if (tick) begin
                qtr <= qtr + 2'd1;
                case (state)
                    START: begin
                        if (qtr == 2'd1) sda_rel <= 1'b0;
                        if (qtr == 2'd3) begin
                            scl   <= 1'b0;
                            state <= CTRL_W;
                        end
                    end
                    RESTART: begin
                        case (qtr)
                            2'd0: sda_rel <= 1'b1;
                            2'd1: scl     <= 1'b1;
                            2'd2: sda_rel <= 1'b0;
                            default: begin
                                scl   <= 1'b0;
                                state <= CTRL_R;
                            end
                        endcase
                    end
                    STOP: begin
                        case (qtr)
                            2'd0: sda_rel <= 1'b0;
                            2'd1: scl     <= 1'b1;
                            2'd2: sda_rel <= 1'b1;
                            default: finish <= 1'b1;
                        endcase
                    end
                    default: begin
                        case (qtr)
                            2'd0: sda_rel <= (bitcnt == 4'd8 || state == DATA_RD) ? 1'b1 : tx_bit;
                            2'd1: scl <= 1'b1;
                            2'd2: begin
                                if (bitcnt == 4'd8) begin
                                    if (state != DATA_RD && sda) i2c_ack <= 1'b1;
                                end else if (state == DATA_RD) begin
                                    rx_sh <= {rx_sh[6:0], sda};
                                end
                            end
                            default: begin
                                scl <= 1'b0;
                                if (bitcnt == 4'd8) begin
                                    bitcnt <= 4'd0;
                                    state  <= i2c_ack ? STOP : nxt_byte;
                                    if (state == DATA_RD) i2c_data_r <= rx_sh;
                                end else begin
                                    bitcnt <= bitcnt + 4'd1;
                                end
                            end
                        endcase
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_byte_master.sv
// Directed bench for i2c_byte_master: bus monitor plus EEPROM-like slave, hand-computed byte lists.
module tb_i2c_byte_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i2c_exec = 1'b0;
    logic        i2c_rh_wl = 1'b0;
    logic [15:0] i2c_addr = 16'h0;
    logic [7:0]  i2c_data_w = 8'h0;
    logic [7:0]  i2c_data_r;
    logic        i2c_done, i2c_ack, i2c_busy, scl;
    wire         sda;

    logic        slave_low = 1'b0;
    pullup (sda);
    assign sda = slave_low ? 1'b0 : 1'bz;

    i2c_byte_master dut (
        .clk(clk), .rst_n(rst_n), .i2c_exec(i2c_exec), .i2c_rh_wl(i2c_rh_wl),
        .i2c_addr(i2c_addr), .i2c_data_w(i2c_data_w), .i2c_data_r(i2c_data_r),
        .i2c_done(i2c_done), .i2c_ack(i2c_ack), .i2c_busy(i2c_busy),
        .scl(scl), .sda(sda)
    );

    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus events: 0x400 = START/Sr, 0x800 = STOP, else {ninth bit, byte}.
    logic [11:0] ev_q[$];
    logic [11:0] exp_q[$];
    int          done_cnt = 0;
    logic        nack_ctrl = 1'b0;
    logic [7:0]  rd_byte = 8'h3C;
    logic        p_scl = 1'b1, p_sda = 1'b1;
    int          m_bits = 0, byte_idx = 0;
    logic [7:0]  m_byte = 8'h0;
    logic        rd_mode = 1'b0;

    always @(negedge clk) begin
        if (i2c_done) done_cnt++;
        if (!rst_n) begin
            m_bits = 0;
            slave_low = 1'b0;
        end else if (scl && p_scl && p_sda && !sda) begin
            ev_q.push_back(12'h400);
            m_bits = 0;
            byte_idx = 0;
        end else if (scl && p_scl && !p_sda && sda) begin
            ev_q.push_back(12'h800);
            m_bits = 0;
        end else if (scl && !p_scl) begin
            if (m_bits < 8) begin
                m_byte = {m_byte[6:0], sda};
                m_bits++;
            end else begin
                ev_q.push_back({3'b000, sda, m_byte});
                if (byte_idx == 0) rd_mode = m_byte[0];
                byte_idx++;
                m_bits = 0;
            end
        end else if (!scl && p_scl) begin
            if (rd_mode && byte_idx == 1) begin
                slave_low = (m_bits < 8) ? !rd_byte[7 - m_bits] : 1'b0;
            end else if (m_bits == 8) begin
                slave_low = !(nack_ctrl && byte_idx == 0);
            end else begin
                slave_low = 1'b0;
            end
        end
        p_scl = scl;
        p_sda = sda;
    end

    task automatic start_txn(input logic rw, input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        i2c_rh_wl = rw; i2c_addr = a; i2c_data_w = d; i2c_exec = 1'b1;
        @(negedge clk);
        i2c_exec = 1'b0;
        check("busy_after_accept", i2c_busy, 1'b1);
    endtask

    task automatic wait_done(input string tag);
        int n;
        int d0;
        d0 = done_cnt;
        n = 0;
        while (!i2c_done && n < 40000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_no_timeout"}, (n < 40000), 1'b1);
        check({tag, "_busy_at_done"}, i2c_busy, 1'b1);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, i2c_done, 1'b0);
        check({tag, "_busy_cleared"}, i2c_busy, 1'b0);
        repeat (20) @(negedge clk);
        check({tag, "_done_pulses"}, done_cnt - d0, 1);
    endtask

    task automatic compare_bus(input string tag);
        check({tag, "_nevents"}, ev_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++)
            check($sformatf("%s_ev%0d", tag, i), ev_q[i], exp_q[i]);
        ev_q.delete();
        exp_q.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_scl", scl, 1'b1);
        check("rst_sda", sda, 1'b1);
        check("rst_done", i2c_done, 1'b0);
        check("rst_ack", i2c_ack, 1'b0);
        check("rst_busy", i2c_busy, 1'b0);
        check("rst_data_r", i2c_data_r, 8'h00);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Write 0x0012 <- 0xA5
        start_txn(1'b0, 16'h0012, 8'hA5);
        wait_done("wr");
        exp_q = '{12'h400, 12'h0A0};
`ifdef I2C_ADDR16_EN
        exp_q.push_back(12'h000);
`endif
        exp_q.push_back(12'h012); exp_q.push_back(12'h0A5); exp_q.push_back(12'h800);
        compare_bus("wr");
        check("wr_ack", i2c_ack, 1'b0);

        // Read 0x00FF -> slave returns 0x3C, master NACKs
        start_txn(1'b1, 16'h00FF, 8'h00);
        wait_done("rd");
        exp_q = '{12'h400, 12'h0A0};
`ifdef I2C_ADDR16_EN
        exp_q.push_back(12'h000);
`endif
        exp_q.push_back(12'h0FF); exp_q.push_back(12'h400); exp_q.push_back(12'h0A1);
        exp_q.push_back(12'h13C); exp_q.push_back(12'h800);
        compare_bus("rd");
        check("rd_data", i2c_data_r, 8'h3C);
        check("rd_ack", i2c_ack, 1'b0);

        // Slave NACKs the control byte
        nack_ctrl = 1'b1;
        start_txn(1'b1, 16'h0077, 8'h00);
        wait_done("nack");
        nack_ctrl = 1'b0;
        exp_q = '{12'h400, 12'h1A0, 12'h800};
        compare_bus("nack");
        check("nack_ack", i2c_ack, 1'b1);
        check("nack_data_held", i2c_data_r, 8'h3C);

        // Exec pulsed mid-transaction is ignored
        start_txn(1'b0, 16'h0021, 8'h11);
        repeat (1000) @(negedge clk);
        i2c_rh_wl = 1'b1; i2c_addr = 16'h0040; i2c_exec = 1'b1;
        @(negedge clk);
        i2c_exec = 1'b0;
        wait_done("mid");
        exp_q = '{12'h400, 12'h0A0};
`ifdef I2C_ADDR16_EN
        exp_q.push_back(12'h000);
`endif
        exp_q.push_back(12'h021); exp_q.push_back(12'h011); exp_q.push_back(12'h800);
        compare_bus("mid");
        check("mid_ack_cleared", i2c_ack, 1'b0);

        // Reset during ADDR_LO
        begin
            int n;
            int d0;
            int need;
`ifdef I2C_ADDR16_EN
            need = 3;
`else
            need = 2;
`endif
            start_txn(1'b0, 16'h0099, 8'h77);
            n = 0;
            while (ev_q.size() < need && n < 20000) begin
                @(negedge clk);
                n++;
            end
            check("rst_mid_reached_addr_lo", (n < 20000), 1'b1);
            repeat (400) @(negedge clk);
            d0 = done_cnt;
            rst_n = 1'b0;
            #1;
            check("rst_mid_scl", scl, 1'b1);
            check("rst_mid_sda", sda, 1'b1);
            check("rst_mid_busy", i2c_busy, 1'b0);
            repeat (5) @(negedge clk);
            rst_n = 1'b1;
            repeat (500) @(negedge clk);
            check("rst_mid_no_done", done_cnt - d0, 0);
            ev_q.delete();
        end

        // Normal write after reset
        start_txn(1'b0, 16'h0001, 8'h66);
        wait_done("post");
        exp_q = '{12'h400, 12'h0A0};
`ifdef I2C_ADDR16_EN
        exp_q.push_back(12'h000);
`endif
        exp_q.push_back(12'h001); exp_q.push_back(12'h066); exp_q.push_back(12'h800);
        compare_bus("post");
        check("post_ack", i2c_ack, 1'b0);

        // Upper address byte must not reach the bus in the 8-bit build
        start_txn(1'b0, 16'h1234, 8'h5A);
        wait_done("a8");
        exp_q = '{12'h400, 12'h0A0};
`ifdef I2C_ADDR16_EN
        exp_q.push_back(12'h012);
`endif
        exp_q.push_back(12'h034); exp_q.push_back(12'h05A); exp_q.push_back(12'h800);
        compare_bus("a8");
        check("a8_ack", i2c_ack, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_byte_master.md
I2C_BYTE_MASTER -- requirements
Module: i2c_byte_master

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- SLAVE_ADDR, 7'h50, 7-bit device address.
- CLK_FREQ, 50_000_000, clk frequency in Hz.
- I2C_FREQ, 250_000, SCL frequency in Hz.

REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- i2c_exec  in  1  one-cycle start request.
- i2c_rh_wl  in  1  1 = read, 0 = write.
- i2c_addr  in  16  word address.
- i2c_data_w  in  8  write byte.
- i2c_data_r  out  8  read byte.
- i2c_done  out  1  one-cycle completion pulse.
- i2c_ack  out  1  1 = NACK seen in last transaction.
- i2c_busy  out  1  transaction in progress.
- scl  out  1  I2C clock.
- sda  inout  1  I2C data, open-drain.

REQ-003 SHALL use one clock, clk; reset rst_n is asynchronous and active-low.

Function
REQ-004 SHALL derive a quarter-SCL-period tick via clock-enable, with QDIV = CLK_FREQ/(I2C_FREQ*4); no derived clocks.
REQ-005 SHALL drive sda only low or high-Z; a logic 1 releases the line.
REQ-006 SHALL accept i2c_exec only in IDLE; SHALL latch i2c_rh_wl, i2c_addr and i2c_data_w on acceptance; SHALL ignore i2c_exec while busy.
REQ-007 SHALL assert i2c_busy from the cycle after acceptance until the cycle i2c_done pulses, inclusive.
REQ-008 SHALL implement states IDLE, START, CTRL_W, ADDR_HI, ADDR_LO, DATA_WR, RESTART, CTRL_R, DATA_RD, STOP.
REQ-009 SHALL follow these write sequences:
- Write: START, CTRL_W ({SLAVE_ADDR,0}), ADDR_HI, ADDR_LO, DATA_WR, STOP.
- Read: START, CTRL_W, ADDR_HI, ADDR_LO, RESTART, CTRL_R ({SLAVE_ADDR,1}), DATA_RD, STOP.
REQ-010 SHALL send bytes MSB first, 9 SCL periods per byte; sda changes only while SCL is low; sda is sampled at mid-high of SCL.
REQ-011 SHALL sample the slave ACK on the 9th clock of every transmitted byte; if it is high, SHALL set i2c_ack=1 and go directly to STOP, skipping the remaining bytes.
REQ-012 SHALL answer DATA_RD with master NACK (sda released on the 9th clock).
REQ-013 SHALL make START/RESTART SDA falling while SCL is high, and STOP SDA rising while SCL is high.
REQ-014 SHALL pulse i2c_done exactly one cycle after STOP completes, then return to IDLE; a new i2c_exec is accepted from the following cycle.
REQ-015 SHALL clear i2c_ack at acceptance of each new transaction and hold it after done.
REQ-016 SHALL update i2c_data_r only when a read completes without NACK; it holds its value otherwise.

Reset
REQ-017 SHALL apply these reset values: scl=1, sda released, i2c_done=0, i2c_ack=0, i2c_busy=0, i2c_data_r=8'h00, state=IDLE, tick counter=0.
REQ-018 SHALL, on reset mid-transaction, abandon the transfer with no STOP generated and no i2c_done pulse.

Configuration
REQ-019 SHALL support macro I2C_ADDR16_EN:
- Defined: the ADDR_HI byte is sent (16-bit word address).
- Undefined: ADDR_HI is skipped, only i2c_addr[7:0] is sent, and i2c_addr[15:8] is ignored.

Structure
REQ-020 SHALL place the state enum, the RW bit constants and the default SLAVE_ADDR in package i2c_pkg.
REQ-021 SHALL implement the quarter-tick divider as sub-module i2c_tick_gen (parameters CLK_FREQ and I2C_FREQ; output tick).

Verification
REQ-022 SHALL cover these directed scenarios with CLK_FREQ=50 MHz and I2C_FREQ=250 kHz (QDIV=50):
- Write addr 0x0012, data 0xA5, slave ACKs all bytes -> bus bytes 0xA0, 0x00, 0x12, 0xA5; STOP; one i2c_done pulse; i2c_ack=0.
- Read addr 0x00FF, slave returns 0x3C -> bus 0xA0, 0x00, 0xFF, Sr, 0xA1, then 0x3C with master NACK; STOP; i2c_data_r=0x3C at done.
- Slave NACKs the control byte -> no further bytes; STOP; i2c_done pulse; i2c_ack=1; i2c_data_r unchanged.
- i2c_exec pulsed mid-transaction with addr 0x0040 -> ignored; the bus shows only the original transaction; one i2c_done pulse.
- rst_n low during ADDR_LO -> scl=1 and sda released immediately; no i2c_done; next write of 0x0001 completes normally.
- I2C_ADDR16_EN undefined, write 0x1234/0x5A -> bus 0xA0, 0x34, 0x5A; done; i2c_ack=0.
